neuron_mac_acc: RTL and testbench

//   Sequential multiply-accumulate front end of one neuron. It consumes a stream of
//   (activation, weight) pairs plus a bias and produces the signed 22-bit Q10.12

---
 rtl/neuron_mac_acc.sv | 126 ++++++++++++
 tb/tb_neuron_mac_acc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_acc.sv
// Neuron multiply-accumulate front end: streams (activation, weight) beats into a
// saturating Q10.12 accumulator seeded with a bias, then presents the sum downstream.
module neuron_mac_acc #(
   parameter int N_INPUTS = 784,
   parameter int ACC_W    = 22,
   parameter int CNT_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        act_in,
   input  logic [7:0]        weight_in,
   output logic [ACC_W-1:0]  acc_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              sat
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_INPUTS);

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic signed [15:0]       prod_p1_q, prod_p1_d;
   logic                     vld_p1_q, vld_p1_d;
   logic signed [ACC_W-1:0]  acc_p2_q, acc_p2_d;
   logic                     sat_q, sat_d;
   logic                     out_valid_q, out_valid_d;

   logic                     in_ready_c, busy_c, count_full, accept, run_start;
   logic signed [15:0]       act_s, weight_s, prod_full;
   logic signed [ACC_W:0]    sum_p2;

   // One guard bit above the accumulator: overflow shows up as the top two bits differing.
   function automatic logic signed [ACC_W-1:0] sat22(input logic signed [ACC_W:0] s);
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
   endfunction

   function automatic logic clamps(input logic signed [ACC_W:0] s);
      return s[ACC_W] != s[ACC_W-1];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)                   state_d = S_ACCUM;
         S_ACCUM: if (vld_p1_q && count_full)  state_d = S_DONE;
         S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
         default:                              state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_full = (count_q == N_LAST);
      in_ready_c = (state_q == S_ACCUM) && !count_full;
      busy_c     = (state_q != S_IDLE);
   end

   always_comb begin
      run_start = (state_q == S_IDLE) && start;
      accept    = in_valid && in_ready_c;

      // Stage 0 -> 1: unsigned activation widened with a zero MSB before the signed multiply.
      act_s     = {8'd0, act_in};
      weight_s  = {{8{weight_in[7]}}, weight_in};
      prod_full = act_s * weight_s;
      prod_p1_d = accept ? prod_full : prod_p1_q;
      vld_p1_d  = accept;

      count_d = count_q;
      if (run_start)   count_d = '0;
      else if (accept) count_d = count_q + CNT_W'(1);

      // Stage 1 -> 2: saturating accumulate of the registered product.
      sum_p2   = {acc_p2_q[ACC_W-1], acc_p2_q} + {{(ACC_W-15){prod_p1_q[15]}}, prod_p1_q};
      acc_p2_d = acc_p2_q;
      sat_d    = sat_q;
      if (run_start) begin
         acc_p2_d = {{(ACC_W-16){bias[15]}}, bias};
         sat_d    = 1'b0;
      end else if (vld_p1_q) begin
         acc_p2_d = sat22(sum_p2);
         if (clamps(sum_p2)) sat_d = 1'b1;
      end

      // Output valid is registered one cycle after DONE is entered and drops on the handshake edge.
      out_valid_d = (state_q == S_DONE) && !(out_valid_q && out_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         prod_p1_q   <= '0;
         vld_p1_q    <= 1'b0;
         acc_p2_q    <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         prod_p1_q   <= prod_p1_d;
         vld_p1_q    <= vld_p1_d;
         acc_p2_q    <= acc_p2_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign busy      = busy_c;
   assign acc_out   = acc_p2_q;
   assign out_valid = out_valid_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: a 4-input instance for functional scenarios and a
// full-size 784-input instance for the saturation runs.
module tb_neuron_mac_acc;

   logic        clk, rst_n;

   logic        start, in_valid, out_ready;
   logic [15:0] bias;
   logic [7:0]  act_in, weight_in;
   logic        in_ready, out_valid, busy, sat;
   logic [21:0] acc_out;

   logic        b_start, b_in_valid, b_out_ready;
   logic [15:0] b_bias;
   logic [7:0]  b_act_in, b_weight_in;
   logic        b_in_ready, b_out_valid, b_busy, b_sat;
   logic [21:0] b_acc_out;

   int n_checks = 0;
   int n_fail   = 0;

   neuron_mac_acc #(.N_INPUTS(4), .ACC_W(22), .CNT_W(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .weight_in(weight_in),
      .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .sat(sat)
   );

   neuron_mac_acc #(.N_INPUTS(784), .ACC_W(22), .CNT_W(10)) u_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .bias(b_bias),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .act_in(b_act_in), .weight_in(b_weight_in),
      .acc_out(b_acc_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .busy(b_busy), .sat(b_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] b);
      start = 1'b1;
      bias  = b;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({out_valid, in_ready, busy, sat} !== 4'b0000 || acc_out !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_small: ov/ir/busy/sat=%b acc=%h, want 0000 / 000000",
                  {out_valid, in_ready, busy, sat}, acc_out);
      end
      n_checks++;
      if ({b_out_valid, b_in_ready, b_busy, b_sat} !== 4'b0000 || b_acc_out !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_big: ov/ir/busy/sat=%b acc=%h, want 0000 / 000000",
                  {b_out_valid, b_in_ready, b_busy, b_sat}, b_acc_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Bias 1.0 plus four products of 1.0 each; also checks exact output latency.
   task automatic test_sum(input string name);
      do_start(16'h1000);
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_accum_entry: busy=%b in_ready=%b, want 1 1", name, busy, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; act_in = 8'h80; weight_in = 8'h20;
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_after_last: out_valid=%b in_ready=%b, want 0 0", name, out_valid, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_edge1: out_valid=%b, want 0", name, out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 22'h005000 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: out_valid=%b acc=%h sat=%b, want 1 005000 0",
                  name, out_valid, acc_out, sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_handshake: out_valid=%b busy=%b, want 0 0", name, out_valid, busy);
      end
   endtask

   // Starts in the cycle right after the previous handshake: 4 x (255 * -128) = -130560.
   task automatic test_negative();
      do_start(16'h0000);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; act_in = 8'hFF; weight_in = 8'h80;
         tick();
      end
      in_valid = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 22'h3E0200 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL negative: out_valid=%b acc=%h sat=%b, want 1 3E0200 0",
                  out_valid, acc_out, sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_saturation(input logic [15:0] b, input logic [7:0] w,
                                  input logic [21:0] exp_acc, input string name);
      b_start = 1'b1; b_bias = b;
      tick();
      b_start = 1'b0;
      n_checks++;
      if (b_sat !== 1'b0 || b_acc_out !== {{6{b[15]}}, b}) begin
         n_fail++;
         $display("FAIL %s_start: sat=%b acc=%h, want 0 %h", name, b_sat, b_acc_out, {{6{b[15]}}, b});
      end
      b_in_valid = 1'b1; b_act_in = 8'hFF; b_weight_in = w;
      for (int i = 0; i < 784; i++) tick();
      b_in_valid = 1'b0;
      n_checks++;
      if (b_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_in_ready_full: in_ready=%b, want 0", name, b_in_ready);
      end
      repeat (2) tick();
      n_checks++;
      if (b_out_valid !== 1'b1 || b_acc_out !== exp_acc || b_sat !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_result: out_valid=%b acc=%h sat=%b, want 1 %h 1",
                  name, b_out_valid, b_acc_out, b_sat, exp_acc);
      end
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [15:0] gaps;
      int          k;
      int          cyc;
      gaps = 16'b1011_0010_0110_1001;
      k    = 0;
      cyc  = 0;
      do_start(16'h1000);
      while (k < 4 && cyc < 40) begin
         in_valid = gaps[cyc % 16];
         // Idle cycles carry poison data that must never be absorbed.
         act_in    = in_valid ? 8'h80 : 8'hFF;
         weight_in = in_valid ? 8'h20 : 8'h80;
         if (in_valid && in_ready) k++;
         tick();
         cyc++;
      end
      in_valid = 1'b1; act_in = 8'hFF; weight_in = 8'h80;
      n_checks++;
      if (k !== 4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accepts: beats=%0d in_ready=%b, want 4 0", k, in_ready);
      end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_out_valid_timeout: out_valid=%b, want 1", out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         start = i[0]; bias = 16'h7000;
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || acc_out !== 22'h005000 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: ov=%b acc=%h ir=%b busy=%b, want 1 005000 0 1",
                     i, out_valid, acc_out, in_ready, busy);
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_handshake: out_valid=%b busy=%b, want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_start(16'h1000);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; act_in = 8'h80; weight_in = 8'h20;
         tick();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, busy, sat} !== 4'b0000 || acc_out !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_mid: ov/ir/busy/sat=%b acc=%h, want 0000 / 000000",
                  {out_valid, in_ready, busy, sat}, acc_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_sum("after_reset");
   endtask

   task automatic test_start_in_accum();
      do_start(16'h1000);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; act_in = 8'h80; weight_in = 8'h20;
         start = 1'b1; bias = 16'h7000;
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 22'h005000 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_accum: out_valid=%b acc=%h sat=%b, want 1 005000 0",
                  out_valid, acc_out, sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      start = 1'b0; bias = '0; in_valid = 1'b0; act_in = '0; weight_in = '0; out_ready = 1'b0;
      b_start = 1'b0; b_bias = '0; b_in_valid = 1'b0; b_act_in = '0; b_weight_in = '0;
      b_out_ready = 1'b0;
      test_reset();
      test_sum("sum");
      test_negative();
      test_saturation(16'h7FFF, 8'h7F, 22'h1FFFFF, "sat_pos");
      test_saturation(16'h8000, 8'h80, 22'h200000, "sat_neg");
      test_backpressure();
      test_reset_mid();
      test_start_in_accum();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
